// File: rtl/shift_add_core_if.sv
// Handshake and data bundle for shift_add_core: operands and start in,
// signed product with done/busy status out.
interface shift_add_core_if #(
  parameter int Word_Length = 8
);
  logic                     Start;
  logic [2*Word_Length-1:0] Multiplicand_Input;
  logic [Word_Length-1:0]   Multiplier_Input;
  logic                     Shift_CA2;
  logic [2*Word_Length-1:0] Product;
  logic                     Done;
  logic                     Busy;

  modport master (
    output Start, Multiplicand_Input, Multiplier_Input, Shift_CA2,
    input  Product, Done, Busy
  );

  modport slave (
    input  Start, Multiplicand_Input, Multiplier_Input, Shift_CA2,
    output Product, Done, Busy
  );
endinterface

// File: rtl/shift_add_core.sv
// Sequential shift-and-add multiplier: W add/shift cycles on latched magnitudes,
// then an optional two's-complement negate into the registered Product.
module shift_add_core #(
  parameter int Word_Length = 8
) (
  input logic            clk,
  input logic            rst,
  shift_add_core_if.slave bus
);
  localparam int W  = Word_Length;
  localparam int PW = 2 * W;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t          r_state, w_next;
  logic [PW-1:0]   r_mcand, r_acc, r_product;
  logic [W-1:0]    r_mplr;
  logic [CW-1:0]   r_count;
  logic            r_neg, r_done, r_busy;
  logic [PW-1:0]   w_addend, w_sum, w_neg;

  assign w_addend = r_mplr[0] ? r_mcand : '0;
  assign w_sum    = r_acc + w_addend;
  assign w_neg    = ~r_acc + PW'(1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.Start) w_next = RUN;
      RUN:     if (r_count == LAST) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Done and Product update on the edge leaving FINISH, so the pulse lands in the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_mcand <= bus.Multiplicand_Input;
            r_mplr  <= bus.Multiplier_Input;
            r_neg   <= bus.Shift_CA2;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_sum;
          r_mcand <= {r_mcand[PW-2:0], 1'b0};
          r_mplr  <= {1'b0, r_mplr[W-1:1]};
          r_count <= r_count + CW'(1);
        end
        FINISH: begin
          r_product <= r_neg ? w_neg : r_acc;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Product = r_product;
  assign bus.Done    = r_done;
  assign bus.Busy    = r_busy;
endmodule

// File: tb/tb_shift_add_core.sv
// Scoreboard bench for shift_add_core (W=8): expected products queued at launch,
// popped and compared when Done pulses.
module tb_shift_add_core;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [2*W-1:0] exp_q[$];

  shift_add_core_if #(.Word_Length(W)) bus ();
  shift_add_core #(.Word_Length(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2*W-1:0] mc, input logic [W-1:0] mp,
                        input logic ng, input bit hold);
    logic [2*W-1:0] mag;
    mag = mc * {{W{1'b0}}, mp};
    exp_q.push_back(ng ? (16'h0000 - mag) : mag);
    bus.Multiplicand_Input = mc;
    bus.Multiplier_Input   = mp;
    bus.Shift_CA2          = ng;
    bus.Start              = 1'b1;
    tick;
    if (!hold) bus.Start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy, output bit ok);
    edges = 1;
    busy  = bus.Busy ? 1 : 0;
    ok    = 1'b0;
    while (!ok && edges < 40) begin
      if (bus.Done) ok = 1'b1;
      else begin
        tick;
        edges++;
        busy += bus.Busy ? 1 : 0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.Start = 1'b0; bus.Multiplicand_Input = '0; bus.Multiplier_Input = '0; bus.Shift_CA2 = 1'b0;
    tick; tick;
    rst = 1'b0;
    n_cmp++;
    if (bus.Product !== 16'h0000 || bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got product=%h done=%b busy=%b, want 0000/0/0",
               bus.Product, bus.Done, bus.Busy);
    end
  endtask

  task automatic test_basic;
    int e, b; bit ok; logic [2*W-1:0] exp;
    launch(16'h0003, 8'h05, 1'b0, 1'b0);
    wait_done(e, b, ok);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.Product !== exp || exp !== 16'h000F) begin
      n_err++; $display("FAIL basic_product: got %h ok=%0d, want 000f", bus.Product, ok);
    end
    n_cmp++;
    if (e !== 10) begin n_err++; $display("FAIL basic_latency: got %0d edges, want 10", e); end
    n_cmp++;
    if (b !== 9) begin n_err++; $display("FAIL basic_busy: got %0d cycles, want 9", b); end
    tick;
    n_cmp++;
    if (bus.Done !== 1'b0 || bus.Product !== exp) begin
      n_err++; $display("FAIL done_pulse_hold: got done=%b product=%h, want 0/%h", bus.Done, bus.Product, exp);
    end
  endtask

  task automatic test_negate;
    int e, b; bit ok; logic [2*W-1:0] exp;
    launch(16'h0001, 8'h01, 1'b1, 1'b0);
    wait_done(e, b, ok);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.Product !== exp || exp !== 16'hFFFF) begin
      n_err++; $display("FAIL negate_minus1: got %h, want ffff", bus.Product);
    end
    tick;
  endtask

  task automatic test_boundary;
    int e, b; bit ok; logic [2*W-1:0] exp;
    launch(16'h0080, 8'h80, 1'b0, 1'b0);
    wait_done(e, b, ok);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.Product !== exp || exp !== 16'h4000) begin
      n_err++; $display("FAIL boundary_pos: got %h, want 4000", bus.Product);
    end
    tick;
    launch(16'h0080, 8'h80, 1'b1, 1'b0);
    wait_done(e, b, ok);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.Product !== exp || exp !== 16'hC000) begin
      n_err++; $display("FAIL boundary_neg: got %h, want c000", bus.Product);
    end
    tick;
  endtask

  task automatic test_zero;
    int e, b; bit ok; logic [2*W-1:0] exp;
    launch(16'h00AB, 8'h00, 1'b1, 1'b0);
    wait_done(e, b, ok);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.Product !== exp || e !== 10) begin
      n_err++; $display("FAIL zero_multiplier: got %h after %0d edges, want %h after 10", bus.Product, e, exp);
    end
    tick;
  endtask

  task automatic test_start_held;
    int e, b; bit ok; logic [2*W-1:0] exp;
    launch(16'h0011, 8'h0D, 1'b0, 1'b1);
    bus.Multiplicand_Input = 16'h00FF; bus.Multiplier_Input = 8'hFF; bus.Shift_CA2 = 1'b1;
    wait_done(e, b, ok);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.Product !== exp) begin
      n_err++; $display("FAIL held_first_operands: got %h, want %h", bus.Product, exp);
    end
    n_cmp++;
    if (bus.Busy !== 1'b0) begin
      n_err++; $display("FAIL held_no_accept_in_finish: got busy=%b, want 0", bus.Busy);
    end
    launch(16'h00FF, 8'hFF, 1'b1, 1'b0);
    wait_done(e, b, ok);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.Product !== exp || e !== 10) begin
      n_err++; $display("FAIL held_second_op: got %h after %0d edges, want %h after 10", bus.Product, e, exp);
    end
    tick;
  endtask

  task automatic test_rst_priority;
    rst = 1'b1; bus.Start = 1'b1;
    tick;
    rst = 1'b0; bus.Start = 1'b0;
    tick;
    n_cmp++;
    if (bus.Busy !== 1'b0 || bus.Product !== 16'h0000) begin
      n_err++; $display("FAIL rst_over_start: got busy=%b product=%h, want 0/0000", bus.Busy, bus.Product);
    end
  endtask

  task automatic test_reset_midrun;
    int e, b; bit ok; bit seen; logic [2*W-1:0] exp;
    launch(16'h0001, 8'h01, 1'b1, 1'b0);
    wait_done(e, b, ok);
    void'(exp_q.pop_front());
    tick;
    launch(16'h0007, 8'h09, 1'b0, 1'b0);
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    void'(exp_q.pop_back());
    n_cmp++;
    if (bus.Busy !== 1'b0 || bus.Product !== 16'h0000 || bus.Done !== 1'b0) begin
      n_err++; $display("FAIL midrun_reset: got busy=%b product=%h done=%b, want 0/0000/0",
                        bus.Busy, bus.Product, bus.Done);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (bus.Done) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL midrun_no_done: got done pulse, want none"); end
    launch(16'h0007, 8'h09, 1'b0, 1'b0);
    wait_done(e, b, ok);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.Product !== exp || exp !== 16'h003F) begin
      n_err++; $display("FAIL after_reset_mul: got %h, want 003f", bus.Product);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int e, b; bit ok; logic [2*W-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      launch(16'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      wait_done(e, b, ok);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!ok || bus.Product !== exp || e !== 10) begin
        n_err++; $display("FAIL b2b_%0d: got %h after %0d edges, want %h after 10", i, bus.Product, e, exp);
      end
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_negate;
    test_boundary;
    test_zero;
    test_start_held;
    test_rst_priority;
    test_reset_midrun;
    test_back_to_back;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shift_add_core.md
SHIFT_ADD_CORE -- requirements
Module: shift_add_core

Interface
REQ-001 Parameter: Word_Length, default 8, operand width W in bits; product width is 2W.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 Start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-006 Multiplicand_Input  input  2W  unsigned multiplicand magnitude, zero-extended, from the Load_Control stage.
REQ-007 Multiplier_Input  input  W  unsigned multiplier magnitude from the Load_Control stage.
REQ-008 Shift_CA2  input  1  result-negate flag from the Load_Control stage.
REQ-009 Product  output  2W  final signed product, two's complement.
REQ-010 Done  output  1  one-cycle pulse marking a new valid Product.
REQ-011 Busy  output  1  high while a multiply is in progress (RUN or FINISH).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, FINISH.
REQ-013 In IDLE with Start=1, the block SHALL load Multiplicand_Input, Multiplier_Input and Shift_CA2 into internal registers, clear the 2W-bit accumulator and the iteration counter, and enter RUN.
REQ-014 In IDLE with Start=0, all registers SHALL hold.
REQ-015 Each RUN cycle SHALL add the multiplicand register to the accumulator when multiplier register bit 0 is 1, shift the multiplicand register left 1 (zero fill), shift the multiplier register right 1 (zero fill), and increment the counter.
REQ-016 Accumulator addition SHALL be 2W bits wide, carry-out discarded.
REQ-017 RUN SHALL last exactly W cycles, independent of operand values (no early exit on zero multiplier).
REQ-018 After the W-th RUN cycle the FSM SHALL enter FINISH.
REQ-019 In FINISH, Product SHALL be registered as the two's complement of the accumulator (invert and add 1, modulo 2^2W) if the latched Shift_CA2 is 1, else the accumulator unchanged; Done SHALL be 1 for that cycle; next state SHALL be IDLE.
REQ-020 Latency: Start sampled at edge k gives Done=1 and valid Product in the cycle after edge k+W+1 (W=8: 10 edges from Start to Done).
REQ-021 Busy SHALL be 1 in RUN and FINISH, 0 in IDLE.
REQ-022 Start SHALL be ignored while Busy=1; inputs changing during RUN SHALL NOT affect the result.
REQ-023 Product SHALL hold its last value until the next FINISH.
REQ-024 Start asserted in the same cycle that FINISH returns to IDLE SHALL NOT be accepted; it is accepted on the next edge where the state is IDLE.
REQ-025 Magnitude 2^(W-1) on both operands SHALL produce the correct magnitude 2^(2W-2) without overflow.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, and clear Product, Done, Busy, the accumulator, the counter and all operand registers, in any state, including mid-RUN.
REQ-027 rst SHALL take priority over Start in the same cycle.
REQ-028 An interrupted multiply SHALL NOT produce a Done pulse.

Verification (W=8)
REQ-029 Multiplicand 0x0003, Multiplier 0x05, Shift_CA2=0, Start one cycle -> Done after 10 edges, Product=0x000F, Busy high for 9 cycles.
REQ-030 Multiplicand 0x0001, Multiplier 0x01, Shift_CA2=1 -> Product=0xFFFF (-1).
REQ-031 Multiplicand 0x0080, Multiplier 0x80, Shift_CA2=0 -> Product=0x4000; then Shift_CA2=1 -> Product=0xC000.
REQ-032 Multiplier 0x00, Shift_CA2=1 -> Product=0x0000, with latency still 10 edges.
REQ-033 Start held high and inputs changed during RUN -> result is from the first operands only; next multiply begins only after returning to IDLE.
REQ-034 rst pulsed at RUN cycle 4 -> IDLE next cycle, Product=0, Busy=0, no Done; a new multiply then completes correctly.
